// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Control unit for a small accumulator machine. One instruction runs as a
// walk through FETCH -> DECODE -> EXEC [-> WB], emitting one-cycle write
// strobes to the datapath, stretched by memory wait states (mem_ready low).
//
// Handshake: mem_ready is the completion strobe for any access the FSM
// is requesting (mem_read or mem_write high). An access completes in the
// cycle mem_ready is high; while it is low the FSM holds its state and its
// strobes unchanged. mem_ready is ignored when no access is requested.
//
// Ports
//   clk, reset      clock, asynchronous active-high reset
//   opcode          IR opcode, stable from DECODE to end of instruction
//   zero_flag       accumulator-zero status (conditional branch)
//   mem_ready       memory access completion
//   run             permits a new fetch
//   pc_write .. o_write   datapath write strobes; pc_src selects branch target
//   alu_control     ALU operation select (valid in EXEC/WB of ALU ops)
//   state           current FSM state code (debug / checker visibility)
//   halted          sticky halt indicator
//   instr_count     retired-instruction counter, wraps
module multicycle_ctrl #(
  parameter int OPC_W = 4,
  parameter int ALU_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero_flag,
  input  logic             mem_ready,
  input  logic             run,
  output logic             pc_write,
  output logic             pc_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             ac_write,
  output logic             b_write,
  output logic             o_write,
  output logic [ALU_W-1:0] alu_control,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_WB     = 3'b011,
    S_HALT   = 3'b100
  } state_t;

  typedef enum logic [3:0] {
    C_ADD, C_SUB, C_OR, C_AND, C_XOR,
    C_JMP, C_JZ, C_OUT,
    C_LDA, C_LDB, C_STR, C_HLT,
    C_NOP
  } cls_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       w_opc8;
  cls_t             w_cls;
  logic             w_is_alu;
  logic [2:0]       w_alu_code;
  logic             w_retire;

  logic w_pc_write, w_pc_src, w_mem_read, w_mem_write;
  logic w_ir_write, w_ac_write, w_b_write, w_o_write;
  logic [ALU_W-1:0] w_alu;

  // Opcode zero-extended to 8 bits so codes above 0xF fall out as NOP for
  // any legal OPC_W.
  assign w_opc8 = 8'(opcode);

  always_comb begin
    w_cls = C_NOP;
    case (w_opc8)
      8'h00:   w_cls = C_ADD;
      8'h01:   w_cls = C_SUB;
      8'h02:   w_cls = C_OR;
      8'h03:   w_cls = C_AND;
      8'h04:   w_cls = C_XOR;
      8'h08:   w_cls = C_JMP;
      8'h09:   w_cls = C_JZ;
      8'h0A:   w_cls = C_OUT;
      8'h0C:   w_cls = C_LDA;
      8'h0D:   w_cls = C_LDB;
      8'h0E:   w_cls = C_STR;
      8'h0F:   w_cls = C_HLT;
      default: w_cls = C_NOP;
    endcase
  end

  always_comb begin
    w_is_alu   = 1'b1;
    w_alu_code = 3'd0;
    case (w_cls)
      C_ADD:   w_alu_code = 3'd0;
      C_SUB:   w_alu_code = 3'd1;
      C_OR:    w_alu_code = 3'd2;
      C_AND:   w_alu_code = 3'd3;
      C_XOR:   w_alu_code = 3'd4;
      default: w_is_alu   = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_pc_write  = 1'b0;
    w_pc_src    = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_ac_write  = 1'b0;
    w_b_write   = 1'b0;
    w_o_write   = 1'b0;
    w_alu       = '0;
    case (r_state)
      S_FETCH: begin
        if (run) begin
          w_mem_read = 1'b1;
          w_ir_write = mem_ready;
          if (mem_ready) w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_cls == C_HLT) begin
          w_next = S_HALT;
        end else begin
          w_pc_write = 1'b1;
          // Memory ops and jumps latch the operand/target into B here.
          w_b_write  = (w_cls == C_LDA) || (w_cls == C_LDB) || (w_cls == C_STR) ||
                       (w_cls == C_JMP) || (w_cls == C_JZ);
          w_next     = S_EXEC;
        end
      end
      S_EXEC: begin
        w_next = S_FETCH;
        if (w_is_alu) begin
          w_alu  = ALU_W'(w_alu_code);
          w_next = S_WB;
        end else begin
          case (w_cls)
            C_LDA: begin
              w_mem_read = 1'b1;
              w_next     = mem_ready ? S_WB : S_EXEC;
            end
            C_LDB: begin
              w_mem_read = 1'b1;
              w_b_write  = mem_ready;
              w_next     = mem_ready ? S_FETCH : S_EXEC;
            end
            C_STR: begin
              w_mem_write = 1'b1;
              w_next      = mem_ready ? S_FETCH : S_EXEC;
            end
            C_JMP: begin
              w_pc_write = 1'b1;
              w_pc_src   = 1'b1;
            end
            C_JZ: begin
              w_pc_write = zero_flag;
              w_pc_src   = zero_flag;
            end
            C_OUT:   w_o_write = 1'b1;
            default: ;
          endcase
        end
      end
      S_WB: begin
        w_next = S_FETCH;
        if (w_is_alu) begin
          w_ac_write = 1'b1;
          w_alu      = ALU_W'(w_alu_code);
        end else if (w_cls == C_LDA) begin
          w_ac_write = 1'b1;
        end
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end

  // An instruction retires when it leaves EXEC/WB for FETCH, or on HLT entry.
  assign w_retire = (((r_state == S_EXEC) || (r_state == S_WB)) && (w_next == S_FETCH)) ||
                    ((r_state != S_HALT) && (w_next == S_HALT));

  // Strobes are gated by reset so they drop the instant reset asserts,
  // even though FETCH itself would otherwise drive mem_read from run.
  assign pc_write    = w_pc_write  & ~reset;
  assign pc_src      = w_pc_src    & ~reset;
  assign mem_read    = w_mem_read  & ~reset;
  assign mem_write   = w_mem_write & ~reset;
  assign ir_write    = w_ir_write  & ~reset;
  assign ac_write    = w_ac_write  & ~reset;
  assign b_write     = w_b_write   & ~reset;
  assign o_write     = w_o_write   & ~reset;
  assign alu_control = reset ? '0 : w_alu;
  assign state       = r_state;
  assign halted      = (r_state == S_HALT) & ~reset;
  assign instr_count = r_cnt;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter OPC_W, default 4, opcode width; legal values are 4 to 8.
REQ-002 SHALL have parameter ALU_W, default 3, alu_control width; legal values are 3 or more.
REQ-003 SHALL have parameter CNT_W, default 16, retired-instruction counter width.
REQ-004 SHALL have port clk  input  1  clock; all state changes occur on the rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port opcode  input  OPC_W  current IR opcode; stable from DECODE through the end of the instruction.
REQ-007 SHALL have port zero_flag  input  1  accumulator-zero status from the datapath.
REQ-008 SHALL have port mem_ready  input  1  memory access completes in the cycle it is high.
REQ-009 SHALL have port run  input  1  permits a new fetch.
REQ-010 SHALL have outputs pc_write, pc_src, mem_read, mem_write, ir_write, ac_write, b_write, o_write, each 1 bit.
- pc_src: 0 selects PC+1, 1 selects the B/branch target.
REQ-011 SHALL have port alu_control  output  ALU_W  ALU operation select.
REQ-012 SHALL have port state  output  3  current FSM state code.
REQ-013 SHALL have port halted  output  1  sticky halt indicator.
REQ-014 SHALL have port instr_count  output  CNT_W  count of retired instructions.

Function
REQ-015 SHALL use states FETCH=000, DECODE=001, EXEC=010, WB=011, HALT=100; state SHALL equal the current code.
REQ-016 SHALL decode opcode zero-extended with these values:
- ADD 0x0, SUB 0x1, OR 0x2, AND 0x3, XOR 0x4
- JMP 0x8, JZ 0x9, OUT 0xA
- LDA 0xC, LDB 0xD, STR 0xE, HLT 0xF
- every other value is a NOP.
REQ-017 SHALL, in FETCH with run=0, drive all strobes 0 and remain in FETCH.
REQ-018 SHALL, in FETCH with run=1, assert mem_read, assert ir_write only while mem_ready=1, and move to DECODE when mem_ready=1; otherwise it remains in FETCH.
REQ-019 SHALL, in DECODE:
- HLT: all strobes 0, next state HALT.
- LDA/LDB/STR/JMP/JZ: pc_write=1 and b_write=1.
- all other opcodes: pc_write=1.
- next state EXEC for every opcode except HLT.
REQ-020 SHALL, in EXEC, drive alu_control for ALU ops: ADD 0, SUB 1, OR 2, AND 3, XOR 4, zero-extended to ALU_W; next state WB.
REQ-021 SHALL, in EXEC for LDA, LDB or STR, behave as follows:
- LDA: mem_read=1; on mem_ready go to WB.
- LDB: mem_read=1, with b_write=mem_ready; on mem_ready go to FETCH.
- STR: mem_write=1; on mem_ready go to FETCH.
- without mem_ready, the block SHALL hold EXEC and keep the same strobes.
REQ-022 SHALL, in EXEC for branches, drive:
- JMP: pc_write=1, pc_src=1.
- JZ: pc_write=zero_flag, pc_src=zero_flag.
- OUT: o_write=1.
- NOP: nothing.
- all four SHALL go to FETCH next.
REQ-023 SHALL, in WB, assert ac_write for ALU ops and LDA, hold alu_control at its EXEC value for ALU ops, and go to FETCH next.
REQ-024 SHALL drive every strobe not named for a state/opcode to 0, alu_control to 0 outside EXEC/WB, and pc_src to 0 except as stated.
REQ-025 SHALL, in HALT, drive all strobes 0 and halted=1, and hold HALT regardless of opcode, run or mem_ready; only reset exits.
REQ-026 SHALL increment instr_count by 1 on every transition into FETCH from EXEC or WB and on entry to HALT, and wrap modulo 2^CNT_W.
REQ-027 SHALL give latencies with zero memory wait:
- ALU/LDA: 4 cycles.
- LDB/STR/JMP/JZ/OUT/NOP: 3 cycles.
- each cycle mem_ready is low SHALL add exactly 1 cycle.

Reset
REQ-028 SHALL, while reset=1, force state=FETCH, halted=0, instr_count=0 and all strobes and alu_control to 0, independent of clk.
REQ-029 SHALL, when reset asserts mid-instruction (including in a memory wait or in HALT), abort immediately; no partial writes are issued after reset asserts.
REQ-030 SHALL, on the first rising edge after reset deasserts, begin FETCH if run=1.

Verification
REQ-031 SHALL verify: ADD (0x0), mem_ready=1, run=1 -> FETCH,DECODE,EXEC,WB; ac_write=1 in WB only with alu_control=0; instr_count 0->1.
REQ-032 SHALL verify: LDA with mem_ready low for 2 EXEC cycles -> EXEC held 3 cycles with mem_read=1; WB ac_write=1; 6 cycles in total.
REQ-033 SHALL verify branches:
- JZ with zero_flag=0 -> no EXEC pc_write.
- JZ with zero_flag=1 -> pc_write=1, pc_src=1.
- JMP -> pc_write=1, pc_src=1.
REQ-034 SHALL verify: HLT -> HALT after DECODE, halted=1, instr_count+1; 20 further cycles with varied opcode stay in HALT with all strobes 0.
REQ-035 SHALL verify: run=0 at FETCH for 5 cycles -> no strobes and state=000; run=1 -> fetch proceeds.
REQ-036 SHALL verify: reset pulsed asynchronously mid-STR wait with mem_write=1 -> mem_write=0 immediately, state=000, instr_count=0; CNT_W=2 with 5 retires -> instr_count=1.
